// File: rtl/keyboard_nmi_receiver.sv
// keyboard_nmi_receiver
//   Deserialises biphase-encoded keyboard frames (start, d0..d7 LSB first,
//   odd parity, stop) into scan codes and raises an NMI request on every
//   completed or failed frame.
// Ports
//   clock, reset_n          system clock, async active-low reset
//   sample_enable           one-clock tick strobe, receiver timebase
//   KBD_DATA                raw serial line (async, idle low)
//   chip_select_n, address  port decode; address 0 = scan code, 1 = status/ctrl
//   read_enable_n,
//   write_enable_n          I/O strobes, acted upon at their rising edge
//   data_bus_in/out         write data / selected register (combinational)
//   NMI                     registered NMI request
// BIT_HALF_TICKS must be even and >= 4.
module keyboard_nmi_receiver #(
  parameter int BIT_HALF_TICKS = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample_enable,
  input  logic       KBD_DATA,
  input  logic       chip_select_n,
  input  logic       address,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus_in,
  output logic [7:0] data_bus_out,
  output logic       NMI
);
  localparam int H  = BIT_HALF_TICKS;
  localparam int CW = $clog2(4*H + 1);
  localparam logic [CW-1:0] T_H1   = CW'(H/2);
  localparam logic [CW-1:0] T_H2   = CW'(H + H/2);
  localparam logic [CW-1:0] T_WRAP = CW'(2*H - 1);
  localparam logic [CW-1:0] T_RCV  = CW'(4*H - 1);

  typedef enum logic [1:0] {S_IDLE, S_CELL, S_STOP, S_RECOVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          h1_q, h1_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    scan_q, scan_d;
  logic          full_q, full_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic          latch_q, latch_d, en_q, en_d, nmi_q;
  logic          kd_meta_q, kd_q, kd_prev_q;
  logic          re_n_q, we_n_q, cs_n_q, addr_q, din7_q, din0_q;
  logic          kd_rise, rd_fire, wr_fire, flush;
  logic          frame_ok, perr_set, ferr_set;
  logic [7:0]    status;
  logic          unused_din;

  assign unused_din = ^data_bus_in[6:1];

  assign kd_rise = kd_q & ~kd_prev_q;
  // Bus cycles act on the strobe's rising edge, using the address/data
  // captured while the strobe was still low.
  assign rd_fire = ~re_n_q & read_enable_n  & ~cs_n_q;
  assign wr_fire = ~we_n_q & write_enable_n & ~cs_n_q;
  assign flush   = wr_fire & addr_q & din0_q;

  // Receiver FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    h1_d     = h1_q;
    shift_d  = shift_q;
    frame_ok = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: if (kd_rise) begin
        state_d = S_CELL;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_CELL: if (sample_enable) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == T_H1) h1_d = kd_q;
        if (cnt_q == T_WRAP) begin
          cnt_d = '0;
          if (idx_q == 4'd9) state_d = S_STOP;
          else               idx_d   = idx_q + 4'd1;
        end
        if (cnt_q == T_H2) begin
          // no mid-cell transition, or a start cell that decodes as 0
          if ((h1_q == kd_q) || (idx_q == 4'd0 && !h1_q)) begin
            ferr_set = 1'b1;
            state_d  = S_RECOVER;
            cnt_d    = '0;
          end else if (idx_q == 4'd9) begin
            if (!(^{h1_q, shift_q})) begin
              perr_set = 1'b1;
              state_d  = S_RECOVER;
              cnt_d    = '0;
            end
          end else if (idx_q != 4'd0) begin
            shift_d = {h1_q, shift_q[7:1]};
          end
        end
      end
      S_STOP: if (sample_enable) begin
        cnt_d = cnt_q + CW'(1);
        if ((cnt_q == T_H1 || cnt_q == T_H2) && kd_q) begin
          ferr_set = 1'b1;
          state_d  = S_RECOVER;
          cnt_d    = '0;
        end else if (cnt_q == T_H2) begin
          frame_ok = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end
      S_RECOVER: begin
        // counts ticks of continuous low line; any high restarts the wait
        if (kd_q) cnt_d = '0;
        else if (sample_enable) begin
          if (cnt_q == T_RCV) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = (state_q == S_IDLE) ? S_IDLE : S_RECOVER;
      cnt_d    = '0;
      frame_ok = 1'b0;
      perr_set = 1'b0;
      ferr_set = 1'b0;
    end
  end

  // Flags and registers. Read clears are applied before new sets so that
  // a frame landing on a scan-code read loads cleanly and sets win races.
  always_comb begin
    scan_d  = scan_q;
    full_d  = full_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    latch_d = latch_q;
    en_d    = en_q;
    if (rd_fire && !addr_q) full_d = 1'b0;
    if (rd_fire && addr_q) begin
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      latch_d = 1'b0;
    end
    if (wr_fire && addr_q) begin
      en_d = din7_q;
      if (din0_q) full_d = 1'b0;
    end
    if (frame_ok) begin
      latch_d = 1'b1;
      if (full_d) ovr_d = 1'b1;
      else begin
        full_d = 1'b1;
        scan_d = shift_q;
      end
    end
    if (perr_set) begin
      perr_d  = 1'b1;
      latch_d = 1'b1;
    end
    if (ferr_set) begin
      ferr_d  = 1'b1;
      latch_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kd_meta_q <= 1'b0;
      kd_q      <= 1'b0;
      kd_prev_q <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      h1_q      <= 1'b0;
      shift_q   <= '0;
      scan_q    <= '0;
      full_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      latch_q   <= 1'b0;
      en_q      <= 1'b0;
      nmi_q     <= 1'b0;
      // strobe history resets to the inactive level so no cycle fires
      re_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      addr_q    <= 1'b0;
      din7_q    <= 1'b0;
      din0_q    <= 1'b0;
    end else begin
      kd_meta_q <= KBD_DATA;
      kd_q      <= kd_meta_q;
      kd_prev_q <= kd_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      h1_q      <= h1_d;
      shift_q   <= shift_d;
      scan_q    <= scan_d;
      full_q    <= full_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      latch_q   <= latch_d;
      en_q      <= en_d;
      nmi_q     <= latch_q & en_q;
      re_n_q    <= read_enable_n;
      we_n_q    <= write_enable_n;
      cs_n_q    <= chip_select_n;
      addr_q    <= address;
      din7_q    <= data_bus_in[7];
      din0_q    <= data_bus_in[0];
    end
  end

  assign status       = {en_q, 2'b00, (state_q != S_IDLE), ovr_q, ferr_q, perr_q, full_q};
  assign data_bus_out = address ? status : scan_q;
  assign NMI          = nmi_q;

endmodule
